// File: rtl/io_pkg.sv
// io_pkg: shared types and defaults for the DCNN IO path.
// Load-sequencer FSM encoding, bus widths, DMA wait limit.
package io_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } load_state_t;

  function automatic int wait_bits(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/io_word_fifo.sv
// io_word_fifo: synchronous word FIFO with sync flush.
// Ports: clk, rst, flush, push/din, pop/dout, full, empty, count.
module io_word_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head word is always presented; caller qualifies it with !empty.
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_load_sequencer.sv
// dma_load_sequencer: buffers a 16-bit word stream, drains it as DMA writes.
// Ports: clk, RST, start/base_addr/word_count, in_* stream, dma_* bus, busy/done/error.
module dma_load_sequencer
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] dma_address,
  output logic [DATA_W-1:0] dma_data,
  output logic              dma_write,
  output logic              dma_read,
  input  logic              dma_done_write,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WW = wait_bits(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  load_state_t       state;
  load_state_t       nstate;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic [15:0]       acc_q;
  logic [15:0]       wr_q;
  logic [WW-1:0]     wait_q;
  logic              err_q;

  logic              job_start;
  logic              push;
  logic              pop;
  logic              timeout_hit;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign job_start   = (state == ST_IDLE) && start;
  assign push        = in_valid && in_ready;
  assign pop         = (state == ST_WRITE) && dma_done_write && !fifo_empty;
  assign timeout_hit = (wait_q == WW'(TIMEOUT));
  // Normal jobs end with an empty FIFO; an aborted job drops leftovers here.
  assign fifo_flush  = (state == ST_FIN);

  io_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .flush (fifo_flush),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (RST) state <= ST_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: begin
        if (start)
          nstate = (word_count == '0) ? ST_FIN : ST_LOAD;
      end
      ST_LOAD: begin
        if (fifo_count != '0) nstate = ST_WRITE;
      end
      ST_WRITE: begin
        if (dma_done_write)   nstate = ST_GAP;
        else if (timeout_hit) nstate = ST_FIN;
      end
      ST_GAP: begin
        nstate = (wr_q < cnt_q) ? ST_LOAD : ST_FIN;
      end
      ST_FIN:  nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      addr_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      wr_q   <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (job_start) begin
        addr_q <= base_addr;
        cnt_q  <= word_count;
        acc_q  <= '0;
        wr_q   <= '0;
        err_q  <= 1'b0;
      end else begin
        if (push) acc_q <= acc_q + 16'd1;
        if (pop) begin
          addr_q <= addr_q + ADDR_W'(1);
          wr_q   <= wr_q + 16'd1;
        end
        if ((state == ST_WRITE) && !dma_done_write && timeout_hit)
          err_q <= 1'b1;
      end
      // Restarts from zero every time WRITE is entered.
      wait_q <= (state == ST_WRITE) ? wait_q + WW'(1) : '0;
    end
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    in_ready    = busy && !fifo_full && (acc_q < cnt_q);
    dma_write   = (state == ST_WRITE);
    dma_address = dma_write ? addr_q : '0;
    dma_data    = dma_write ? fifo_dout : '0;
    dma_read    = 1'b0;
    done        = (state == ST_FIN);
    error       = err_q;
  end

endmodule

// File: tb/tb_dma_load_sequencer.sv
// tb_dma_load_sequencer: scoreboard bench for dma_load_sequencer.
// Source and DMA models run on negedge; scenarios run at posedge+1.
module tb_dma_load_sequencer;

  localparam int TIMEOUT = 255;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dma_address;
  logic [15:0] dma_data;
  logic        dma_write;
  logic        dma_read;
  logic        dma_done_write = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  txn_t        sb_q[$];
  txn_t        exp_t;
  logic [15:0] src_q[$];
  logic [15:0] exp_addr = '0;
  logic [15:0] dmem [0:65535];
  int dma_lat = 2;
  int dcnt = 0;
  int wr_count = 0;
  int popped = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int wcycles = 0;
  int cyc = 0;
  int first_acc_cyc = -1;
  int first_wr_cyc = -1;
  int job_cnt = 0;
  int job_acc0 = 0;
  int ready_err = 0;
  bit chk_ready = 0;
  bit stall_full = 0;
  logic exp_rdy;

  dma_load_sequencer #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dma_address    (dma_address),
    .dma_data       (dma_data),
    .dma_write      (dma_write),
    .dma_read       (dma_read),
    .dma_done_write (dma_done_write),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RST) begin
      dma_done_write = 1'b0;
      dcnt = 0;
      in_valid = 1'b0;
    end else begin
      if (dma_write) wcycles++;
      if (done) done_cnt++;
      if (dma_done_write) begin
        dma_done_write = 1'b0;
        popped++;
        vectors++;
        if (dma_write !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_cycle dma_write=%b required 0", dma_write);
        end
      end else if (dma_write) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        dcnt++;
        if (dma_lat != 0 && dcnt >= dma_lat) begin
          dcnt = 0;
          dma_done_write = 1'b1;
          wr_count++;
          dmem[dma_address] = dma_data;
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write addr=%h data=%h", dma_address, dma_data);
          end else begin
            exp_t = sb_q.pop_front();
            if (dma_address !== exp_t.addr || dma_data !== exp_t.data || dma_read !== 1'b0) begin
              miscompares++;
              $display("FAIL dma_txn got addr=%h data=%h rd=%b required addr=%h data=%h rd=0",
                       dma_address, dma_data, dma_read, exp_t.addr, exp_t.data);
            end
          end
        end
      end else begin
        dcnt = 0;
      end
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
      if (chk_ready && busy) begin
        exp_rdy = ((acc_cnt - job_acc0) < job_cnt) && ((acc_cnt - popped) < DEPTH);
        if (in_ready !== exp_rdy) ready_err++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back({exp_addr, in_data});
        exp_addr++;
        acc_cnt++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
        void'(src_q.pop_front());
      end else if (in_valid && busy && (acc_cnt - popped) == DEPTH) begin
        stall_full = 1;
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    word_count = n;
    exp_addr = b;
    job_cnt = n;
    job_acc0 = acc_cnt;
    first_acc_cyc = -1;
    first_wr_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL job_done no done within %0d cycles", budget);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({in_ready, dma_write, dma_read, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("FAIL %s_ctrl rdy/wr/rd/busy/done/err=%b required 000000", tag,
               {in_ready, dma_write, dma_read, busy, done, error});
    end
    vectors++;
    if (dma_address !== 16'h0 || dma_data !== 16'h0) begin
      miscompares++;
      $display("FAIL %s_bus addr=%h data=%h required 0000/0000", tag, dma_address, dma_data);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int w0 = wr_count;
    dma_lat = 2;
    src_q.push_back(16'hF001);
    src_q.push_back(16'hF0F0);
    do_start(16'h0000, 16'd2);
    wait_done(100);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_error got %b required 0", error);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt - d0 != 1 || wr_count - w0 != 2) begin
      miscompares++;
      $display("FAIL basic_counts done=%0d writes=%0d required 1/2", done_cnt - d0, wr_count - w0);
    end
    vectors++;
    if (dmem[16'h0000] !== 16'hF001 || dmem[16'h0001] !== 16'hF0F0) begin
      miscompares++;
      $display("FAIL basic_readback got %h,%h required F001,F0F0", dmem[16'h0000], dmem[16'h0001]);
    end
    vectors++;
    if (first_wr_cyc - first_acc_cyc != 1) begin
      miscompares++;
      $display("FAIL basic_latency edge gap=%0d required 1", first_wr_cyc - first_acc_cyc);
    end
  endtask

  task automatic test_backpressure();
    int w0 = wr_count;
    int a0 = acc_cnt;
    dma_lat = 5;
    stall_full = 0;
    ready_err = 0;
    for (int i = 0; i < 7; i++) src_q.push_back(16'hA000 + 16'(i));
    chk_ready = 1;
    do_start(16'h1000, 16'd6);
    wait_done(500);
    chk_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (wr_count - w0 != 6 || acc_cnt - a0 != 6 || src_q.size() != 1) begin
      miscompares++;
      $display("FAIL bp_counts writes=%0d accepted=%0d left=%0d required 6/6/1",
               wr_count - w0, acc_cnt - a0, src_q.size());
    end
    vectors++;
    if (!stall_full || ready_err != 0) begin
      miscompares++;
      $display("FAIL bp_ready stall_seen=%0d ready_errs=%0d required 1/0", stall_full, ready_err);
    end
    vectors++;
    if (dmem[16'h1005] !== 16'hA005 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_last got %h pending=%0d required A005/0", dmem[16'h1005], sb_q.size());
    end
    src_q.delete();
  endtask

  task automatic test_wrap();
    dma_lat = 2;
    src_q.push_back(16'h1111);
    src_q.push_back(16'h2222);
    src_q.push_back(16'h3333);
    do_start(16'hFFFE, 16'd3);
    wait_done(200);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dmem[16'hFFFE] !== 16'h1111 || dmem[16'hFFFF] !== 16'h2222 || dmem[16'h0000] !== 16'h3333) begin
      miscompares++;
      $display("FAIL wrap got %h,%h,%h required 1111,2222,3333",
               dmem[16'hFFFE], dmem[16'hFFFF], dmem[16'h0000]);
    end
  endtask

  task automatic test_zero_count();
    int c0 = wcycles;
    int d0 = done_cnt;
    do_start(16'h2000, 16'd0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_fin done/busy/err=%b%b%b required 110", done, busy, error);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle done/busy=%b%b required 00", done, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (wcycles != c0 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL zero_nowrite write_cycles=%0d dones=%0d required 0/1", wcycles - c0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int c0 = wcycles;
    dma_lat = 0;
    src_q.push_back(16'hBEEF);
    src_q.push_back(16'hCAFE);
    do_start(16'h3000, 16'd2);
    wait_done(600);
    vectors++;
    if (error !== 1'b1 || wcycles - c0 != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL timeout_abort err=%b write_cycles=%0d required 1/%0d", error, wcycles - c0, TIMEOUT + 1);
    end
    @(posedge clk); #1;
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sticky err/busy=%b%b required 10", error, busy);
    end
    sb_q.delete();
    popped = acc_cnt;
    dma_lat = 2;
    src_q.push_back(16'h5A5A);
    do_start(16'h0040, 16'd1);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear err=%b required 0", error);
    end
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dmem[16'h0040] !== 16'h5A5A || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_flush got %h pending=%0d required 5A5A/0", dmem[16'h0040], sb_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int w0 = wr_count;
    int d0;
    dma_lat = 3;
    for (int i = 0; i < 4; i++) src_q.push_back(16'hC000 + 16'(i));
    do_start(16'h0500, 16'd4);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (wr_count - w0 >= 1) break;
    end
    vectors++;
    if (wr_count - w0 != 1) begin
      miscompares++;
      $display("FAIL midrst_first writes=%0d required 1", wr_count - w0);
    end
    RST = 1'b1;
    src_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    RST = 1'b0;
    sb_q.delete();
    popped = acc_cnt;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL midrst_nodone dones=%0d required 0", done_cnt - d0);
    end
    w0 = wr_count;
    d0 = done_cnt;
    dma_lat = 1;
    src_q.push_back(16'h7777);
    src_q.push_back(16'h8888);
    do_start(16'h0600, 16'd2);
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dmem[16'h0600] !== 16'h7777 || dmem[16'h0601] !== 16'h8888 ||
        wr_count - w0 != 2 || done_cnt - d0 != 1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_rerun got %h,%h writes=%0d dones=%0d err=%b required 7777,8888/2/1/0",
               dmem[16'h0600], dmem[16'h0601], wr_count - w0, done_cnt - d0, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_timeout();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
